// File: rtl/noc_axi4_bridge_pkg.sv
// Shared types and helpers for the NoC/AXI4 bridge response path.
// Header layout follows the three-flit NoC message header.
package noc_axi4_bridge_pkg;

    localparam int MSG_HEADER_WIDTH = 192;

    localparam logic [7:0] MSG_NC_LOAD_REQ      = 8'd14;
    localparam logic [7:0] MSG_NC_STORE_REQ     = 8'd15;
    localparam logic [7:0] MSG_LOAD_MEM         = 8'd19;
    localparam logic [7:0] MSG_STORE_MEM        = 8'd20;
    localparam logic [7:0] MSG_LOAD_MEM_ACK     = 8'd24;
    localparam logic [7:0] MSG_STORE_MEM_ACK    = 8'd25;
    localparam logic [7:0] MSG_NC_LOAD_MEM_ACK  = 8'd26;
    localparam logic [7:0] MSG_NC_STORE_MEM_ACK = 8'd27;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        DATA
    } ser_state_e;

    // First header flit; also the layout of header_in[63:0]
    typedef struct packed {
        logic [13:0] chipid;
        logic [7:0]  x;
        logic [7:0]  y;
        logic [3:0]  fbits;
        logic [7:0]  len;
        logic [7:0]  mtype;
        logic [7:0]  mshrid;
        logic [5:0]  options_1;
    } noc_hdr_t;

    // Source routing fields, header_in[191:158]
    typedef struct packed {
        logic [13:0] chipid;
        logic [7:0]  x;
        logic [7:0]  y;
        logic [3:0]  fbits;
    } noc_src_t;

    function automatic int nflits(input int axi_w, input int noc_w);
        return axi_w / noc_w;
    endfunction

    function automatic logic resp_type_known(input logic [7:0] t);
        return (t == MSG_LOAD_MEM) || (t == MSG_NC_LOAD_REQ) ||
               (t == MSG_STORE_MEM) || (t == MSG_NC_STORE_REQ);
    endfunction

    function automatic noc_hdr_t mk_resp_header(
        input noc_src_t   src,
        input logic [7:0] mtype,
        input logic [7:0] mshrid,
        input logic [7:0] nfl,
        input logic       err
    );
        noc_hdr_t h;
        h.chipid    = src.chipid;
        h.x         = src.x;
        h.y         = src.y;
        h.fbits     = src.fbits;
        h.mshrid    = mshrid;
        h.options_1 = {5'b0, err};
        h.len       = 8'd0;
        h.mtype     = mtype;
        unique case (mtype)
            MSG_LOAD_MEM: begin
                h.mtype = MSG_LOAD_MEM_ACK;
                h.len   = nfl;
            end
            MSG_NC_LOAD_REQ: begin
                h.mtype = MSG_NC_LOAD_MEM_ACK;
                h.len   = nfl;
            end
            MSG_STORE_MEM:    h.mtype = MSG_STORE_MEM_ACK;
            MSG_NC_STORE_REQ: h.mtype = MSG_NC_STORE_MEM_ACK;
            default:          h.mtype = mtype;
        endcase
        return h;
    endfunction

endpackage

// File: rtl/noc_axi4_resp_fifo.sv
// Generic synchronous FIFO holding queued responses.
// Pushes when full and pops when empty are ignored.
module noc_axi4_resp_fifo #(
    parameter int  DEPTH   = 2,
    parameter type entry_t = logic [7:0],
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  entry_t        wdata,
    input  logic          pop,
    output entry_t        rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    entry_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/noc_axi4_resp_ser.sv
// Serialises queued AXI responses into a NoC header flit plus data flits.
// Optional feature: NOC_AXI4_SER_ERR_RESP_EN adds the in_err port.
module noc_axi4_resp_ser
    import noc_axi4_bridge_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 512,
    parameter int NOC_DATA_WIDTH = 64,
    parameter int FIFO_DEPTH     = 2,
    parameter int SWAP_ENDIANESS = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [MSG_HEADER_WIDTH-1:0] header_in,
    input  logic [AXI_DATA_WIDTH-1:0]   data_in,
    input  logic                        in_val,
    output logic                        in_rdy,
`ifdef NOC_AXI4_SER_ERR_RESP_EN
    input  logic                        in_err,
`endif
    output logic [NOC_DATA_WIDTH-1:0]   flit_out,
    output logic                        flit_out_val,
    input  logic                        flit_out_rdy,
    output logic                        busy
);

    localparam int NFLITS = nflits(AXI_DATA_WIDTH, NOC_DATA_WIDTH);
    localparam int BW     = (NFLITS > 1) ? $clog2(NFLITS) : 1;
    localparam int NB     = NOC_DATA_WIDTH / 8;
    localparam int CW     = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        noc_hdr_t                  hdr;
        logic [AXI_DATA_WIDTH-1:0] data;
    } resp_entry_t;

    ser_state_e  state;
    ser_state_e  state_nxt;
    logic [BW-1:0] beat;
    logic [BW-1:0] beat_nxt;

    resp_entry_t   wentry;
    resp_entry_t   head;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    logic          more;
    logic          last;
    logic          err;
    logic          unused_hdr;

    noc_src_t   src;
    logic [7:0] req_type;
    logic [7:0] req_mshr;

    logic [NFLITS-1:0][NOC_DATA_WIDTH-1:0] slices;
    logic [NOC_DATA_WIDTH-1:0]             slice;
    logic [NOC_DATA_WIDTH-1:0]             slice_sw;

`ifdef NOC_AXI4_SER_ERR_RESP_EN
    assign err = in_err;
`else
    assign err = 1'b0;
`endif

    assign src        = header_in[191:158];
    assign req_type   = header_in[21:14];
    assign req_mshr   = header_in[13:6];
    assign unused_hdr = ^header_in;

    // Errored loads still send a full burst, just with zero data
    assign wentry.hdr  = mk_resp_header(src, req_type, req_mshr,
                                        8'(NFLITS), err);
    assign wentry.data = err ? '0 : data_in;

    assign in_rdy = !full;
    assign push   = in_val && !full;

    noc_axi4_resp_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (resp_entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (wentry),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assert property (@(posedge clk) disable iff (rst)
        push |-> resp_type_known(req_type));

    assign last = (beat == BW'(NFLITS - 1));
    // An entry will still be at the head after this pop
    assign more = (count > CW'(1)) || push;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            beat  <= '0;
        end else begin
            state <= state_nxt;
            beat  <= beat_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        beat_nxt  = beat;
        pop       = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty || push) state_nxt = HDR;
            end
            HDR: begin
                if (flit_out_rdy) begin
                    if (head.hdr.len == 8'd0) begin
                        pop       = 1'b1;
                        state_nxt = more ? HDR : IDLE;
                    end else begin
                        state_nxt = DATA;
                        beat_nxt  = '0;
                    end
                end
            end
            DATA: begin
                if (flit_out_rdy) begin
                    if (last) begin
                        pop       = 1'b1;
                        beat_nxt  = '0;
                        state_nxt = more ? HDR : IDLE;
                    end else begin
                        beat_nxt = beat + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign slices = head.data;
    assign slice  = slices[beat];

    always_comb begin
        slice_sw = slice;
        if (SWAP_ENDIANESS != 0) begin
            for (int i = 0; i < NB; i++) begin
                slice_sw[i*8 +: 8] = slice[(NB-1-i)*8 +: 8];
            end
        end
    end

    always_comb begin
        flit_out     = '0;
        flit_out_val = (state != IDLE);
        busy         = !empty || (state != IDLE);
        unique case (state)
            HDR:     flit_out = NOC_DATA_WIDTH'(head.hdr);
            DATA:    flit_out = slice_sw;
            default: flit_out = '0;
        endcase
    end

endmodule

// File: tb/tb_noc_axi4_resp_ser.sv
// Testbench for noc_axi4_resp_ser: scoreboard of expected flits per message.
// Optional error-response checks run when NOC_AXI4_SER_ERR_RESP_EN is defined.
module tb_noc_axi4_resp_ser;

    localparam int AW = 512;
    localparam int NW = 64;
    localparam int NF = AW / NW;
    localparam int HW = 192;

    localparam logic [7:0] T_NC_LOAD  = 8'd14;
    localparam logic [7:0] T_NC_STORE = 8'd15;
    localparam logic [7:0] T_LOAD     = 8'd19;
    localparam logic [7:0] T_STORE    = 8'd20;

`ifdef NOC_AXI4_SER_ERR_RESP_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [HW-1:0] header_in = '0;
    logic [AW-1:0] data_in = '0;
    logic          in_val = 1'b0;
    logic          in_rdy;
    logic [NW-1:0] flit_out;
    logic          flit_out_val;
    logic          flit_out_rdy = 1'b0;
    logic          busy;

    logic [HW-1:0] s_header_in = '0;
    logic [AW-1:0] s_data_in = '0;
    logic          s_in_val = 1'b0;
    logic          s_in_rdy;
    logic [NW-1:0] s_flit_out;
    logic          s_flit_out_val;
    logic          s_flit_out_rdy = 1'b0;
    logic          s_busy;

`ifdef NOC_AXI4_SER_ERR_RESP_EN
    logic in_err = 1'b0;
    logic s_in_err = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    logic [63:0] expq[$];

    noc_axi4_resp_ser #(
        .AXI_DATA_WIDTH(AW), .NOC_DATA_WIDTH(NW),
        .FIFO_DEPTH(2), .SWAP_ENDIANESS(0)
    ) dut (
        .clk(clk), .rst(rst), .header_in(header_in), .data_in(data_in),
        .in_val(in_val), .in_rdy(in_rdy),
`ifdef NOC_AXI4_SER_ERR_RESP_EN
        .in_err(in_err),
`endif
        .flit_out(flit_out), .flit_out_val(flit_out_val),
        .flit_out_rdy(flit_out_rdy), .busy(busy)
    );

    noc_axi4_resp_ser #(
        .AXI_DATA_WIDTH(AW), .NOC_DATA_WIDTH(NW),
        .FIFO_DEPTH(2), .SWAP_ENDIANESS(1)
    ) dut_swap (
        .clk(clk), .rst(rst), .header_in(s_header_in), .data_in(s_data_in),
        .in_val(s_in_val), .in_rdy(s_in_rdy),
`ifdef NOC_AXI4_SER_ERR_RESP_EN
        .in_err(s_in_err),
`endif
        .flit_out(s_flit_out), .flit_out_val(s_flit_out_val),
        .flit_out_rdy(s_flit_out_rdy), .busy(s_busy)
    );

    function automatic logic [HW-1:0] mk_req(input logic [7:0] t, input logic [7:0] mshr,
                                              input logic [7:0] x, input logic [7:0] y,
                                              input logic [13:0] chip, input logic [3:0] fb);
        logic [HW-1:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        r[191:178] = chip;
        r[177:170] = x;
        r[169:162] = y;
        r[161:158] = fb;
        r[21:14]   = t;
        r[13:6]    = mshr;
        return r;
    endfunction

    function automatic logic [HW-1:0] rand_req();
        logic [7:0] t;
        case ($urandom_range(0, 3))
            0: t = T_LOAD;
            1: t = T_STORE;
            2: t = T_NC_LOAD;
            default: t = T_NC_STORE;
        endcase
        return mk_req(t, 8'($urandom()), 8'($urandom()), 8'($urandom()),
                      14'($urandom()), 4'($urandom()));
    endfunction

    function automatic logic [AW-1:0] rand_data();
        logic [AW-1:0] d;
        for (int i = 0; i < AW / 32; i++) d[i*32 +: 32] = $urandom();
        return d;
    endfunction

    function automatic bit is_load(input logic [7:0] t);
        return (t == T_LOAD) || (t == T_NC_LOAD);
    endfunction

    function automatic logic [7:0] ack_type(input logic [7:0] t);
        case (t)
            T_LOAD:     return 8'd24;
            T_STORE:    return 8'd25;
            T_NC_LOAD:  return 8'd26;
            T_NC_STORE: return 8'd27;
            default:    return t;
        endcase
    endfunction

    function automatic logic [63:0] exp_hdr(input logic [HW-1:0] req, input logic e);
        logic [7:0] len;
        len = is_load(req[21:14]) ? 8'(NF) : 8'd0;
        return {req[191:178], req[177:170], req[169:162], req[161:158],
                len, ack_type(req[21:14]), req[13:6], 5'd0, e};
    endfunction

    function automatic logic [63:0] bswap(input logic [63:0] v);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[i*8 +: 8] = v[(7-i)*8 +: 8];
        return r;
    endfunction

    function automatic void model_push(input logic [HW-1:0] req, input logic [AW-1:0] d,
                                       input logic e, input bit swap);
        logic [63:0] s;
        expq.push_back(exp_hdr(req, e));
        if (is_load(req[21:14])) begin
            for (int i = 0; i < NF; i++) begin
                s = e ? 64'd0 : d[i*NW +: NW];
                expq.push_back(swap ? bswap(s) : s);
            end
        end
    endfunction

    // Drives one input cycle; records the message when it will be accepted
    task automatic offer(input logic v, input logic [HW-1:0] req, input logic [AW-1:0] d,
                         input logic e, output bit acc);
        in_val    = v;
        header_in = req;
        data_in   = d;
`ifdef NOC_AXI4_SER_ERR_RESP_EN
        in_err    = e;
`endif
        acc = v && in_rdy;
        if (acc) model_push(req, d, e & ERR_EN, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (flit_out_val !== 1'b0) begin
            errors++; $display("FAIL reset_val: got %b required 0", flit_out_val);
        end
        checks++;
        if (flit_out !== '0) begin
            errors++; $display("FAIL reset_flit: got %h required 0", flit_out);
        end
        checks++;
        if (in_rdy !== 1'b1) begin
            errors++; $display("FAIL reset_in_rdy: got %b required 1", in_rdy);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b required 0", busy);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_load();
        logic [HW-1:0] req;
        logic [AW-1:0] d;
        logic [63:0] hdr_lit;
        bit acc;
        req = mk_req(T_LOAD, 8'd7, 8'd3, 8'd5, 14'd0, 4'd0);
        for (int i = 0; i < NF; i++) d[i*NW +: NW] = 64'h0101010101010101 * 64'(i + 1);
        hdr_lit = {14'd0, 8'd3, 8'd5, 4'd0, 8'd8, 8'd24, 8'd7, 6'd0};
        flit_out_rdy = 1'b1;
        checks++;
        if (in_rdy !== 1'b1) begin
            errors++; $display("FAIL idle_in_rdy: got %b required 1", in_rdy);
        end
        offer(1'b1, req, d, 1'b0, acc);
        @(negedge clk);
        offer(1'b0, '0, '0, 1'b0, acc);
        checks++;
        if (flit_out !== hdr_lit) begin
            errors++; $display("FAIL load_hdr_lit: got %h required %h", flit_out, hdr_lit);
        end
        for (int k = 0; k <= NF; k++) begin
            checks++;
            if (flit_out_val !== 1'b1 || flit_out !== expq[0]) begin
                errors++;
                $display("FAIL load_flit%0d: got val=%b %h required val=1 %h",
                         k, flit_out_val, flit_out, expq[0]);
            end
            void'(expq.pop_front());
            @(negedge clk);
        end
        checks++;
        if (flit_out_val !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL load_done: got val=%b busy=%b required 0 0", flit_out_val, busy);
        end
    endtask

    task automatic test_back_to_back();
        bit acc;
        flit_out_rdy = 1'b1;
        expq.delete();
        for (int n = 0; n <= 11; n++) begin
            if (n >= 1 && n <= 10) begin
                checks++;
                if (expq.size() == 0 || flit_out_val !== 1'b1 || flit_out !== expq[0]) begin
                    errors++;
                    $display("FAIL b2b_flit%0d: got val=%b %h required val=1 %h",
                             n, flit_out_val, flit_out, (expq.size() != 0) ? expq[0] : 64'd0);
                end
                if (expq.size() != 0) void'(expq.pop_front());
            end
            if (n == 11) begin
                checks++;
                if (flit_out_val !== 1'b0) begin
                    errors++; $display("FAIL b2b_end: got val=%b required 0", flit_out_val);
                end
            end
            if (n == 0) offer(1'b1, rand_req_t(T_STORE), rand_data(), 1'b0, acc);
            else if (n == 1) offer(1'b1, rand_req_t(T_NC_LOAD), rand_data(), 1'b0, acc);
            else offer(1'b0, '0, '0, 1'b0, acc);
            if (n <= 1) begin
                checks++;
                if (!acc) begin
                    errors++; $display("FAIL b2b_accept%0d: got in_rdy=0 required 1", n);
                end
            end
            @(negedge clk);
        end
    endtask

    function automatic logic [HW-1:0] rand_req_t(input logic [7:0] t);
        return mk_req(t, 8'($urandom()), 8'($urandom()), 8'($urandom()),
                      14'($urandom()), 4'($urandom()));
    endfunction

    task automatic test_backpressure();
        logic [HW-1:0] r[3];
        logic [AW-1:0] d[3];
        int idx = 0;
        int cyc = 0;
        bit acc;
        expq.delete();
        for (int i = 0; i < 3; i++) begin
            r[i] = rand_req_t(T_LOAD);
            d[i] = rand_data();
        end
        flit_out_rdy = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (flit_out_val) begin
                checks++;
                if (flit_out !== expq[0]) begin
                    errors++; $display("FAIL bp_hold: got %h required %h", flit_out, expq[0]);
                end
            end
            if (c == 5) begin
                checks++;
                if (in_rdy !== 1'b0 || idx != 2) begin
                    errors++;
                    $display("FAIL bp_full: got in_rdy=%b pushes=%0d required 0 2", in_rdy, idx);
                end
            end
            if (idx < 3) begin
                offer(1'b1, r[idx], d[idx], 1'b0, acc);
                if (acc) idx++;
            end else offer(1'b0, '0, '0, 1'b0, acc);
            @(negedge clk);
        end
        flit_out_rdy = 1'b1;
        while ((idx < 3 || expq.size() != 0) && cyc < 60) begin
            cyc++;
            if (flit_out_val) begin
                checks++;
                if (expq.size() == 0 || flit_out !== expq[0]) begin
                    errors++;
                    $display("FAIL bp_drain: got %h required %h", flit_out,
                             (expq.size() != 0) ? expq[0] : 64'd0);
                end
                if (expq.size() != 0) void'(expq.pop_front());
            end
            if (idx < 3) begin
                offer(1'b1, r[idx], d[idx], 1'b0, acc);
                if (acc) idx++;
            end else offer(1'b0, '0, '0, 1'b0, acc);
            @(negedge clk);
        end
        checks++;
        if (cyc >= 60 || flit_out_val !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_finish: got cycles=%0d val=%b busy=%b required <60 0 0",
                     cyc, flit_out_val, busy);
        end
    endtask

    task automatic test_random();
        int sent = 0;
        int cyc = 0;
        bit have = 0;
        bit hold = 0;
        bit acc;
        bit rdy;
        logic [HW-1:0] preq;
        logic [AW-1:0] pdata;
        logic pe;
        logic [NW-1:0] pflit;
        expq.delete();
        while ((sent < 1000 || expq.size() != 0) && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            if (hold) begin
                checks++;
                if (flit_out_val !== 1'b1 || flit_out !== pflit) begin
                    errors++;
                    $display("FAIL rand_stable: got val=%b %h required val=1 %h",
                             flit_out_val, flit_out, pflit);
                end
            end
            rdy = ($urandom_range(0, 1) == 1);
            flit_out_rdy = rdy;
            if (flit_out_val) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++; $display("FAIL rand_extra: got %h required no flit", flit_out);
                end else begin
                    if (flit_out !== expq[0]) begin
                        errors++;
                        $display("FAIL rand_flit: got %h required %h", flit_out, expq[0]);
                    end
                    if (rdy) void'(expq.pop_front());
                end
            end
            hold  = flit_out_val && !rdy;
            pflit = flit_out;
            if (sent < 1000 && (have || $urandom_range(0, 3) != 0)) begin
                if (!have) begin
                    preq  = rand_req();
                    pdata = rand_data();
                    pe    = ($urandom_range(0, 7) == 0);
                    have  = 1'b1;
                end
                offer(1'b1, preq, pdata, pe, acc);
                if (acc) begin
                    sent++;
                    have = 1'b0;
                end
            end else offer(1'b0, '0, '0, 1'b0, acc);
        end
        @(negedge clk);
        flit_out_rdy = 1'b0;
        checks++;
        if (cyc >= 40000 || flit_out_val !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rand_finish: got cycles=%0d left=%0d val=%b busy=%b required drained",
                     cyc, expq.size(), flit_out_val, busy);
        end
    endtask

    task automatic test_reset_mid();
        bit acc;
        logic [HW-1:0] req;
        expq.delete();
        flit_out_rdy = 1'b1;
        offer(1'b1, rand_req_t(T_LOAD), rand_data(), 1'b0, acc);
        @(negedge clk);
        offer(1'b0, '0, '0, 1'b0, acc);
        for (int n = 0; n < 4; n++) begin
            void'(expq.pop_front());
            @(negedge clk);
        end
        checks++;
        if (flit_out_val !== 1'b1 || flit_out !== expq[0]) begin
            errors++;
            $display("FAIL rstmid_beat3: got val=%b %h required val=1 %h",
                     flit_out_val, flit_out, expq[0]);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (flit_out_val !== 1'b0 || flit_out !== '0 || busy !== 1'b0 || in_rdy !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_async: got val=%b flit=%h busy=%b in_rdy=%b required 0 0 0 1",
                     flit_out_val, flit_out, busy, in_rdy);
        end
        expq.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (flit_out_val !== 1'b0) begin
            errors++; $display("FAIL rstmid_stale: got val=%b required 0", flit_out_val);
        end
        req = rand_req_t(T_STORE);
        offer(1'b1, req, rand_data(), 1'b0, acc);
        @(negedge clk);
        offer(1'b0, '0, '0, 1'b0, acc);
        checks++;
        if (flit_out_val !== 1'b1 || flit_out !== exp_hdr(req, 1'b0)) begin
            errors++;
            $display("FAIL rstmid_hdr: got val=%b %h required val=1 %h",
                     flit_out_val, flit_out, exp_hdr(req, 1'b0));
        end
        expq.delete();
        @(negedge clk);
        checks++;
        if (flit_out_val !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_done: got val=%b busy=%b required 0 0", flit_out_val, busy);
        end
    endtask

    task automatic test_swap();
        logic [HW-1:0] req;
        logic [AW-1:0] d;
        expq.delete();
        req = rand_req_t(T_LOAD);
        d = rand_data();
        d[63:0] = 64'h0102030405060708;
        s_flit_out_rdy = 1'b1;
        checks++;
        if (s_in_rdy !== 1'b1) begin
            errors++; $display("FAIL swap_in_rdy: got %b required 1", s_in_rdy);
        end
        s_in_val    = 1'b1;
        s_header_in = req;
        s_data_in   = d;
        model_push(req, d, 1'b0, 1'b1);
        @(negedge clk);
        s_in_val = 1'b0;
        for (int k = 0; k <= NF; k++) begin
            checks++;
            if (s_flit_out_val !== 1'b1 || s_flit_out !== expq[0]) begin
                errors++;
                $display("FAIL swap_flit%0d: got val=%b %h required val=1 %h",
                         k, s_flit_out_val, s_flit_out, expq[0]);
            end
            if (k == 1) begin
                checks++;
                if (s_flit_out !== 64'h0807060504030201) begin
                    errors++;
                    $display("FAIL swap_lit: got %h required 0807060504030201", s_flit_out);
                end
            end
            void'(expq.pop_front());
            @(negedge clk);
        end
        checks++;
        if (s_flit_out_val !== 1'b0 || s_busy !== 1'b0) begin
            errors++;
            $display("FAIL swap_done: got val=%b busy=%b required 0 0", s_flit_out_val, s_busy);
        end
        s_flit_out_rdy = 1'b0;
    endtask

`ifdef NOC_AXI4_SER_ERR_RESP_EN
    task automatic test_err();
        bit acc;
        expq.delete();
        flit_out_rdy = 1'b1;
        offer(1'b1, rand_req_t(T_LOAD), rand_data(), 1'b1, acc);
        @(negedge clk);
        offer(1'b0, '0, '0, 1'b0, acc);
        checks++;
        if (flit_out[0] !== 1'b1) begin
            errors++; $display("FAIL err_opt1: got %b required 1", flit_out[0]);
        end
        for (int k = 0; k <= NF; k++) begin
            checks++;
            if (flit_out_val !== 1'b1 || flit_out !== expq[0] ||
                (k > 0 && flit_out !== '0)) begin
                errors++;
                $display("FAIL err_flit%0d: got val=%b %h required val=1 %h",
                         k, flit_out_val, flit_out, expq[0]);
            end
            void'(expq.pop_front());
            @(negedge clk);
        end
        checks++;
        if (flit_out_val !== 1'b0) begin
            errors++; $display("FAIL err_done: got val=%b required 0", flit_out_val);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_load();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_mid();
        test_swap();
`ifdef NOC_AXI4_SER_ERR_RESP_EN
        test_err();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
